// File: rtl/uart_reg_responder.sv
// UART command responder: decodes 'W'/'R' frames into register-port accesses.
// Define UART_RESP_CHECKSUM_EN for XOR-checked frames and two-byte responses.
module uart_reg_responder #(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr_en,
  input  logic [7:0]        reg_rdata,
  output logic              cmd_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef UART_RESP_CHECKSUM_EN
    GET_CSUM,
`endif
    EXEC,
    SEND,
    WAIT_HI,
    WAIT_LO
  } state_e;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [7:0]        txd_q, txd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdat_q, wdat_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              waiting;
  logic              tmo_hit;
  logic              addr_bad;
  state_e            after_data;
`ifdef UART_RESP_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              pend_q, pend_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      txd_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      tmo_q   <= '0;
`ifdef UART_RESP_CHECKSUM_EN
      csum_q  <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      txd_q   <= txd_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      tmo_q   <= tmo_d;
`ifdef UART_RESP_CHECKSUM_EN
      csum_q  <= csum_d;
      pend_q  <= pend_d;
`endif
    end
  end

  always_comb begin
    waiting = (state_q == GET_ADDR) || (state_q == GET_DATA);
`ifdef UART_RESP_CHECKSUM_EN
    waiting = waiting || (state_q == GET_CSUM);
    after_data = GET_CSUM;
`else
    after_data = EXEC;
`endif
    tmo_hit  = waiting && (tmo_q == TMO_MAX);
    addr_bad = (rx_data >> ADDR_W) != 8'h00;
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    txd_d   = txd_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    tmo_d   = tmo_q;
`ifdef UART_RESP_CHECKSUM_EN
    csum_d  = csum_q;
    pend_d  = pend_q;
`endif
    if (rx_done) begin
      tmo_d = '0;
    end else if (waiting && tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (rx_done) begin
`ifdef UART_RESP_CHECKSUM_EN
          csum_d = rx_data;
`endif
          if (rx_data == OP_W || rx_data == OP_R) begin
            wr_d    = (rx_data == OP_W);
            tmo_d   = '0;
            state_d = GET_ADDR;
          end else begin
            err_d   = 1'b1;
            txd_d   = RSP_E;
            state_d = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rx_done) begin
          addr_d = rx_data[ADDR_W-1:0];
`ifdef UART_RESP_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (addr_bad) begin
            err_d   = 1'b1;
            txd_d   = RSP_E;
            state_d = SEND;
          end else if (wr_q) begin
            state_d = GET_DATA;
          end else begin
            state_d = after_data;
          end
        end
      end
      GET_DATA: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rx_done) begin
          wdat_d  = rx_data;
`ifdef UART_RESP_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
          state_d = after_data;
        end
      end
`ifdef UART_RESP_CHECKSUM_EN
      GET_CSUM: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rx_done) begin
          if (rx_data == csum_q) begin
            state_d = EXEC;
          end else begin
            err_d   = 1'b1;
            txd_d   = RSP_E;
            state_d = SEND;
          end
        end
      end
`endif
      EXEC: begin
        txd_d   = wr_q ? RSP_K : reg_rdata;
`ifdef UART_RESP_CHECKSUM_EN
        pend_d  = 1'b1;
`endif
        state_d = SEND;
      end
      SEND: state_d = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_d = IDLE;
`ifdef UART_RESP_CHECKSUM_EN
          // successful responses are followed by their complement byte
          if (pend_q) begin
            pend_d  = 1'b0;
            txd_d   = txd_q ^ 8'hFF;
            state_d = SEND;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_start  = (state_q == SEND);
  assign reg_wr_en = (state_q == EXEC) && wr_q;
  assign tx_data   = txd_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdat_q;
  assign cmd_err   = err_q;

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Command responder on the far side of the UART link: decodes host command frames from the byte receiver and performs register reads/writes on a simple register port.
- Returns one response byte per command through the byte transmitter.
- Sits between the uart receiver/transmitter pair and a peripheral register bank. It turns the raw serial link into a register-access slave.

Parameters:
- ADDR_W, 4, register address width; valid addresses are 0 to 2^ADDR_W-1.
- TIMEOUT_CYC, 100000, maximum clk cycles allowed between bytes of one command before it is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- rx_data  in  8  received byte; valid when rx_done is high
- rx_done  in  1  one-cycle pulse per received byte
- tx_busy  in  1  high while the transmitter shifts a frame
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data
- tx_data  out  8  response byte; held stable from the tx_start pulse until tx_busy falls
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  8  register write data
- reg_wr_en  out  1  one-cycle register write strobe
- reg_rdata  in  8  combinational read data for reg_addr
- cmd_err  out  1  one-cycle pulse on a malformed or timed-out command

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - tx_start, reg_wr_en and cmd_err go to 0.
  - tx_data, reg_addr and reg_wdata go to 0.
  - Timeout counter goes to 0.
- Frames:
  - Write: 0x57 ('W'), addr, data -> response 0x4B ('K').
  - Read: 0x52 ('R'), addr -> response is the register value.
  - Error response: 0x45 ('E').
- IDLE:
  - On rx_done with 0x57, go to GET_ADDR with a write flag; with 0x52, go to GET_ADDR with a read flag.
  - Any other byte: pulse cmd_err, load 0x45, go to SEND.
- GET_ADDR: on rx_done, latch reg_addr = rx_data[ADDR_W-1:0].
  - If rx_data[7:ADDR_W] != 0: pulse cmd_err, load 0x45, go to SEND.
  - Else if write: go to GET_DATA.
  - Else if read: go to EXEC.
- GET_DATA: on rx_done, latch reg_wdata, go to EXEC.
- EXEC (exactly 1 cycle):
  - Write: reg_wr_en = 1 for this cycle, load tx_data = 0x4B.
  - Read: load tx_data = reg_rdata, sampled this cycle.
  - Go to SEND.
- SEND: tx_start = 1 for one cycle, go to WAIT_HI.
- WAIT_HI: wait for tx_busy = 1, then go to WAIT_LO.
- WAIT_LO: wait for tx_busy = 0, then go to IDLE.
- Latency: tx_start is asserted 2 cycles after the rx_done of the final command byte (EXEC, then SEND).
- Timeout:
  - The counter clears on every rx_done and on entry to GET_ADDR.
  - It increments each cycle in GET_ADDR/GET_DATA.
  - When it reaches TIMEOUT_CYC-1: pulse cmd_err, return to IDLE, send no response, issue no register write.
  - The counter saturates and never wraps.
- rx_done during EXEC/SEND/WAIT_HI/WAIT_LO: the byte is dropped silently; no state change.
- rx_done in the same cycle the timeout fires: the timeout wins; the byte is dropped.
- reg_addr and reg_wdata hold their last values between commands.
- reg_wr_en never asserts outside EXEC.
- Reset mid-transfer: immediate return to IDLE. tx_start is not reissued; the transmitter finishes any frame already started.

Optional Feature:
- Macro: UART_RESP_CHECKSUM_EN.
- When defined:
  - Each command carries one extra trailing byte equal to the XOR of all preceding command bytes, received in new state GET_CSUM.
  - On a mismatch: pulse cmd_err, suppress the register write, respond 0x45.
  - Each successful response becomes two bytes, value then (value XOR 0xFF). The second byte goes through a second SEND/WAIT_HI/WAIT_LO pass.
  - The timeout also covers GET_CSUM.
- When undefined: frames are exactly as above; no GET_CSUM state or logic is present.

Test Plan:
- Write then read: rx bytes 0x57, 0x03, 0xA5 -> reg_wr_en pulse with reg_addr = 3, reg_wdata = 0xA5; tx_data = 0x4B. Then rx 0x52, 0x03 with reg_rdata = 0xA5 -> tx_data = 0xA5, tx_start 2 cycles after the last rx_done.
- Bad opcode: rx 0x11 -> cmd_err pulse, tx_data = 0x45, no reg_wr_en.
- Out-of-range address (ADDR_W = 4): rx 0x57, 0x13 -> cmd_err, response 0x45, FSM back in IDLE; the following 0x52, 0x01 is processed normally.
- Timeout: rx 0x57, then no byte for TIMEOUT_CYC cycles -> cmd_err pulse, no tx_start, no reg_wr_en. A new 0x52, 0x00 afterwards is answered.
- Busy overlap: hold tx_busy high 200 cycles after tx_start and inject rx 0x52 meanwhile -> byte dropped; no second tx_start until tx_busy falls and a fresh command arrives.
- Async reset asserted in GET_DATA -> all outputs 0 immediately; the next 0x57, 0x02, 0x7E completes with 'K'. With UART_RESP_CHECKSUM_EN: 0x57, 0x02, 0x7E, checksum 0x2B -> responses 0x4B then 0xB4; checksum 0x00 -> 0x45 and no write.
